// File: rtl/mux8way_arbiter_pkg.sv
// Shared definitions for the 8-way merging arbiter and its round-robin picker.
`ifndef MUX8WAY_ARBITER_PKG_SV
`define MUX8WAY_ARBITER_PKG_SV

// Part-select of channel i out of a flat bus holding 8 channels of w bits each.
`define MUX8_CH_SLICE(i, w) (int'(i))*(w) +: (w)

package mux8way_arbiter_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Next channel in round-robin order; the 3-bit add wraps 7 back to 0.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
        return c + SEL_W'(1);
    endfunction

endpackage

`endif

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick8
    import mux8way_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              any_o
);

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        idx_o = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_i[ptr_i + SEL_W'(k)]) idx_o = ptr_i + SEL_W'(k);
        end
        any_o = |req_i;
        gnt_o = any_o ? (NUM_CH'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mux8way_arbiter.sv
// Eight source channels merged onto one registered output stream.
// Round-robin between packets, locked to one channel until its last beat.
module mux8way_arbiter
    import mux8way_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [WIDTH-1:0]   out_data_q;
    logic [SEL_W-1:0]   out_sel_q;
    logic               out_last_q;
    logic               out_valid_q;

    logic [NUM_CH-1:0]  pick_gnt;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               can_load;
    logic [SEL_W-1:0]   src_idx;
    logic               accept;
    logic               acc_last;

    rr_pick8 u_pick (
        .req_i (in_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // The output register can take a beat when empty or being drained this cycle.
    assign can_load = !out_valid_q | out_ready;
    assign src_idx  = (state_q == LOCK) ? cur_q : pick_idx;
    assign accept   = |in_ready;
    assign acc_last = in_last[src_idx];

    // State register: FSM state, round-robin pointer and locked channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
        end
    end

    // Next state: a last beat releases to ARB and advances ptr; any other beat locks.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        if (accept) begin
            if (acc_last) begin
                state_d = ARB;
                ptr_d   = next_ch(src_idx);
            end else begin
                state_d = LOCK;
                cur_d   = src_idx;
            end
        end
    end

    // Outputs: grant at most one channel; nothing is accepted during reset.
    always_comb begin
        in_ready = '0;
        if (!reset) begin
            case (state_q)
                ARB:     if (pick_any && can_load) in_ready = pick_gnt;
                LOCK:    in_ready[cur_q] = can_load & in_valid[cur_q];
                default: in_ready = '0;
            endcase
        end
    end

    // Output stage: load accepted beats, drop valid when drained with nothing new.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_data_q  <= in_data[`MUX8_CH_SLICE(src_idx, WIDTH)];
            out_sel_q   <= src_idx;
            out_last_q  <= acc_last;
            out_valid_q <= 1'b1;
        end else if (can_load) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8way_arbiter.sv
// Directed bench for mux8way_arbiter: per-channel source queues and an output scoreboard.
module tb_mux8way_arbiter;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_valid;
    logic [7:0]     in_last;
    logic [7:0]     in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    mux8way_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] src_q [8][$];   // {last, data}
    logic [19:0] sb [$];         // {last, sel, data}
    logic [7:0]  fire;
    logic [W-1:0] frz_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int ch, input logic [15:0] d, input bit last, input bit expect_out);
        src_q[ch].push_back({last, d});
        if (expect_out) sb.push_back({last, 3'(ch), d});
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            if (src_q[i].size() != 0) begin
                in_valid[i]       = 1'b1;
                in_data[i*W +: W] = src_q[i][0][15:0];
                in_last[i]        = src_q[i][0][16];
            end else begin
                in_valid[i]       = 1'b0;
                in_data[i*W +: W] = '0;
                in_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: check the beat leaving on this edge, then retire accepted source beats.
    task automatic tick();
        #1;
        fire = in_valid & in_ready;
        if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra_beat: got %0h expected no beat", {out_last, out_sel, out_data});
            end
            if (sb.size() != 0) chk("sb_beat", {12'b0, out_last, out_sel, out_data}, {12'b0, sb.pop_front()});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        drive();
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        // Reset: a valid source must not be granted while reset is high.
        load(1, 16'h1111, 1'b1, 1'b0);
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
        end
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        src_q[1].delete();
        drive();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_out_valid", 32'(out_valid), 32'h0);
            chk("idle_in_ready", 32'(in_ready), 32'h0);
        end

        // Single-beat packets on 0, 3, 7; channel 0 comes back only after 7.
        load(0, 16'h0A00, 1'b1, 1'b1);
        load(3, 16'h0A03, 1'b1, 1'b1);
        load(7, 16'h0A07, 1'b1, 1'b1);
        load(0, 16'h0A10, 1'b1, 1'b1);
        drive(); #1;
        tick(); chk("sp_sel0", 32'(out_sel), 32'd0); chk("sp_vld0", 32'(out_valid), 32'd1);
        tick(); chk("sp_sel3", 32'(out_sel), 32'd3); chk("sp_vld3", 32'(out_valid), 32'd1);
        tick(); chk("sp_sel7", 32'(out_sel), 32'd7); chk("sp_vld7", 32'(out_valid), 32'd1);
        tick(); chk("sp_sel0b", 32'(out_sel), 32'd0); chk("sp_data0b", 32'(out_data), 32'h0A10);

        // Channel 2 four-beat packet holds the output while channel 5 waits.
        for (int b = 1; b <= 4; b++) load(2, 16'(16'h2000 + b), b == 4, 1'b1);
        load(5, 16'h5001, 1'b1, 1'b1);
        drive(); #1;
        chk("lock_rdy5_pre", 32'(in_ready[5]), 32'd0);
        for (int b = 1; b <= 4; b++) begin
            tick();
            chk("lock_sel2", 32'(out_sel), 32'd2);
            chk("lock_data", 32'(out_data), 32'(16'h2000 + b));
            if (b < 4) chk("lock_rdy5", 32'(in_ready[5]), 32'd0);
        end
        tick();
        chk("lock_after_sel5", 32'(out_sel), 32'd5);
        chk("lock_after_last", 32'(out_last), 32'd1);

        // Backpressure: three frozen cycles, then drain with nothing lost or doubled.
        load(6, 16'h6001, 1'b1, 1'b1);
        load(1, 16'h1001, 1'b1, 1'b1);
        load(6, 16'h6002, 1'b1, 1'b1);
        drive(); #1;
        tick();
        chk("bp_first_sel", 32'(out_sel), 32'd6);
        out_ready = 1'b0;
        #1;
        frz_data = out_data;
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'(frz_data));
            chk("bp_out_sel", 32'(out_sel), 32'd6);
        end
        out_ready = 1'b1;
        tick(); chk("bp_resume_sel1", 32'(out_sel), 32'd1);
        tick(); chk("bp_resume_sel6", 32'(out_sel), 32'd6);

        // Reset in the middle of a channel 4 packet: only its first beat is seen.
        load(4, 16'h4001, 1'b0, 1'b1);
        load(4, 16'h4002, 1'b0, 1'b0);
        load(4, 16'h4003, 1'b1, 1'b0);
        drive(); #1;
        tick();
        chk("mid_sel4", 32'(out_sel), 32'd4);
        reset = 1'b1;
        src_q[4].delete();
        drive(); #1;
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;

        // All eight channels valid: strict rotation from 0 at one beat per cycle.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) load(i, 16'(16'h0B00 | (i << 4) | r), 1'b1, 1'b1);
        drive(); #1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            if (k < 10) chk("rr_sel", 32'(out_sel), 32'(k % 8));
        end

        // Wrap: after 7, lone channel 1 wins immediately; then ptr=2 beats channel 0.
        load(1, 16'h1A01, 1'b1, 1'b1);
        drive(); #1;
        chk("wrap_rdy1", 32'(in_ready), 32'h02);
        tick();
        chk("wrap_sel1", 32'(out_sel), 32'd1);
        load(2, 16'h2A02, 1'b1, 1'b1);
        load(0, 16'h0A0F, 1'b1, 1'b1);
        drive(); #1;
        chk("wrap_rdy2", 32'(in_ready), 32'h04);
        tick(); chk("wrap_sel2", 32'(out_sel), 32'd2);
        tick(); chk("wrap_sel0", 32'(out_sel), 32'd0);

        for (int c = 0; c < 4; c++) tick();
        chk("final_out_valid", 32'(out_valid), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
